// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: serialises one parallel word per handshake into
// start bit, DBIT data bits (LSB first) and a stop period, paced by s_tick.
module uart_tx_sequencer #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned OS      = 16,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int unsigned SMax = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int unsigned SW   = (SMax > 1) ? $clog2(SMax) : 1;
  localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] SLastBit  = SW'(OS - 1);
  localparam logic [SW-1:0] SLastStop = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast     = NW'(DBIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: count s_tick pulses within each bit period.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Ticks in the acceptance cycle are deliberately not counted.
        if (tx_start) begin
          state_d = StStart;
          s_d     = '0;
          b_d     = din;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == SLastBit) begin
            state_d = StData;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SLastBit) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SLastStop) begin
            state_d = StIdle;
            s_d     = '0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the next state so tx and state change on the same edge.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = b_d[0];
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_ready     = (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: scoreboard of sent words, serial
// decoder on tx, plus timing checks on done pulses and bit boundaries.
module tb_uart_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_ready, tx_done_tick, tx;
  logic       tx_start32 = 1'b0;
  logic [7:0] din32 = 8'h00;
  logic       tx_ready32, tx_done_tick32, tx32;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done32_cnt = 0;
  int tick_period = 4;
  int tick_cnt = 0;
  logic [7:0] exp_q[$];

  uart_tx_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .tx_start    (tx_start),
    .din         (din),
    .tx_ready    (tx_ready),
    .tx_done_tick(tx_done_tick),
    .tx          (tx)
  );

  uart_tx_sequencer #(.SB_TICK(32)) dut32 (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .tx_start    (tx_start32),
    .din         (din32),
    .tx_ready    (tx_ready32),
    .tx_done_tick(tx_done_tick32),
    .tx          (tx32)
  );

  always #5 clk = ~clk;

  // Baud tick source: one pulse every tick_period clks (1 = tied high).
  always @(negedge clk) begin
    if (tick_cnt >= tick_period - 1) begin
      tick_cnt = 0;
      s_tick = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_done_tick32 === 1'b1) done32_cnt <= done32_cnt + 1;
  end

  function automatic logic tx_of(input bit use32);
    return use32 ? tx32 : tx;
  endfunction

  function automatic bit pop_exp(output logic [7:0] e);
    if (exp_q.size() == 0) begin
      e = 8'h00;
      return 1'b0;
    end
    e = exp_q.pop_front();
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] v);
    @(negedge clk);
    din = v;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic send32(input logic [7:0] v);
    @(negedge clk);
    din32 = v;
    tx_start32 = 1'b1;
    @(negedge clk);
    tx_start32 = 1'b0;
  endtask

  // Hunt for a start bit, then sample mid-bit; ok clears on timeout or framing error.
  task automatic rx_frame(input bit use32, output logic [7:0] data, output bit ok,
                          output int fall_cyc);
    int len;
    int n;
    len = 16 * tick_period;
    ok = 1'b1;
    data = 8'h00;
    fall_cyc = 0;
    n = 0;
    while (tx_of(use32) !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      ok = 1'b0;
      return;
    end
    fall_cyc = cyc;
    repeat (len / 2) @(negedge clk);
    if (tx_of(use32) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (len) @(negedge clk);
      data[i] = tx_of(use32);
    end
    repeat (len) @(negedge clk);
    if (tx_of(use32) !== 1'b1) ok = 1'b0;
  endtask

  task automatic wait_done(input bit use32, output bit ok, output int dcyc);
    int n;
    n = 0;
    while ((use32 ? tx_done_tick32 : tx_done_tick) !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 4000);
    dcyc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
    total++;
    if (tx_done_tick !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b want=0", tx_done_tick);
    end
    total++;
    if (tx32 !== 1'b1) begin bad++; $display("FAIL reset_tx32 got=%b want=1", tx32); end
    total++;
    if (tx_ready32 !== 1'b1) begin
      bad++; $display("FAIL reset_ready32 got=%b want=1", tx_ready32);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] got, e;
    bit ok, okd;
    int f, dc, d0;
    tick_period = 4;
    d0 = done_cnt;
    exp_q.push_back(8'hA5);
    send(8'hA5);
    rx_frame(1'b0, got, ok, f);
    wait_done(1'b0, okd, dc);
    repeat (3) @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_framing got=bad want=ok"); end
    total++;
    if (!pop_exp(e) || got !== e) begin
      bad++; $display("FAIL basic_data got=%h want=%h", got, e);
    end
    total++;
    if (!okd || dc - f < 637 || dc - f > 643) begin
      bad++; $display("FAIL basic_done_time got=%0d want=637..643", dc - f);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_busy();
    logic [7:0] got, e;
    bit ok, okd;
    int f, dc, d0, ready_hi, low, n;
    tick_period = 4;
    d0 = done_cnt;
    ready_hi = 0;
    exp_q.push_back(8'hA5);
    fork
      begin
        send(8'hA5);
        repeat (200) @(negedge clk);
        din = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
      begin
        rx_frame(1'b0, got, ok, f);
        wait_done(1'b0, okd, dc);
      end
      begin
        n = 0;
        while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (tx_done_tick !== 1'b1 && n < 1000) begin
          if (tx_ready !== 1'b0) ready_hi++;
          @(negedge clk);
          n++;
        end
      end
    join
    low = 0;
    repeat (700) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    total++;
    if (!ok || !okd) begin bad++; $display("FAIL busy_framing got=bad want=ok"); end
    total++;
    if (!pop_exp(e) || got !== e) begin
      bad++; $display("FAIL busy_data got=%h want=%h", got, e);
    end
    total++;
    if (ready_hi != 0) begin
      bad++; $display("FAIL busy_ready got=%0d_high_clks want=0", ready_hi);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL busy_done_count got=%0d want=1", done_cnt - d0);
    end
    total++;
    if (low != 0) begin bad++; $display("FAIL busy_second_frame got=%0d_low_clks want=0", low); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got0, got1, e;
    bit ok0, ok1, okd0, okd1;
    int f0, f1, dc0, dc1, d0, n;
    tick_period = 4;
    d0 = done_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    fork
      begin
        @(negedge clk);
        din = 8'h00;
        tx_start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (tx_ready !== 1'b0 && n < 100);
        din = 8'hFF;
        n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        @(negedge clk);
        tx_start = 1'b0;
      end
      begin
        rx_frame(1'b0, got0, ok0, f0);
        wait_done(1'b0, okd0, dc0);
        rx_frame(1'b0, got1, ok1, f1);
        wait_done(1'b0, okd1, dc1);
      end
    join
    repeat (20) @(negedge clk);
    total++;
    if (!ok0 || !okd0) begin bad++; $display("FAIL b2b_framing0 got=bad want=ok"); end
    total++;
    if (!pop_exp(e) || got0 !== e) begin
      bad++; $display("FAIL b2b_data0 got=%h want=%h", got0, e);
    end
    total++;
    if (!ok1 || !okd1) begin bad++; $display("FAIL b2b_framing1 got=bad want=ok"); end
    total++;
    if (!pop_exp(e) || got1 !== e) begin
      bad++; $display("FAIL b2b_data1 got=%h want=%h", got1, e);
    end
    total++;
    if (f1 - dc0 != 1) begin
      bad++; $display("FAIL b2b_gap got=%0d want=1", f1 - dc0);
    end
    total++;
    if (done_cnt - d0 != 2) begin
      bad++; $display("FAIL b2b_done_count got=%0d want=2", done_cnt - d0);
    end
  endtask

  task automatic test_stop_len();
    logic [7:0] got, e;
    bit ok;
    int f, d0, n, rise, dc, drop;
    logic b7;
    tick_period = 4;
    d0 = done32_cnt;
    drop = 0;
    rise = 0;
    dc = 0;
    b7 = 1'b1;
    exp_q.push_back(8'h55);
    fork
      send32(8'h55);
      rx_frame(1'b1, got, ok, f);
      begin
        n = 0;
        while (tx32 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        repeat (544) @(negedge clk);
        b7 = tx32;
        n = 0;
        while (tx32 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        rise = cyc;
        n = 0;
        while (tx_done_tick32 !== 1'b1 && n < 400) begin
          if (tx32 !== 1'b1) drop++;
          @(negedge clk);
          n++;
        end
        dc = cyc;
      end
    join
    repeat (3) @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL stop_framing got=bad want=ok"); end
    total++;
    if (!pop_exp(e) || got !== e) begin
      bad++; $display("FAIL stop_data got=%h want=%h", got, e);
    end
    total++;
    if (b7 !== 1'b0) begin bad++; $display("FAIL stop_bit7 got=%b want=0", b7); end
    total++;
    if (dc - rise != 128) begin
      bad++; $display("FAIL stop_length got=%0d want=128", dc - rise);
    end
    total++;
    if (drop != 0) begin bad++; $display("FAIL stop_level got=%0d_low_clks want=0", drop); end
    total++;
    if (done32_cnt - d0 != 1) begin
      bad++; $display("FAIL stop_done_count got=%0d want=1", done32_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, e;
    bit ok, okd;
    int f, dc, d0;
    tick_period = 4;
    d0 = done_cnt;
    send(8'hA5);
    repeat (288) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b want=1", tx); end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", tx_ready); end
    total++;
    if (tx_done_tick !== 1'b0) begin
      bad++; $display("FAIL rstmid_done got=%b want=0", tx_done_tick);
    end
    reset = 1'b0;
    repeat (800) @(negedge clk);
    total++;
    if (done_cnt != d0) begin
      bad++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt - d0);
    end
    exp_q.push_back(8'h81);
    send(8'h81);
    rx_frame(1'b0, got, ok, f);
    wait_done(1'b0, okd, dc);
    total++;
    if (!ok || !okd) begin bad++; $display("FAIL rstmid_framing got=bad want=ok"); end
    total++;
    if (!pop_exp(e) || got !== e) begin
      bad++; $display("FAIL rstmid_data got=%h want=%h", got, e);
    end
  endtask

  task automatic test_tick_high();
    logic       wave[161];
    logic       dn[161];
    logic [7:0] v, got, e;
    logic       want;
    int         wave_bad, dn_bad;
    v = 8'hA5;
    tick_period = 1;
    repeat (2) @(negedge clk);
    exp_q.push_back(v);
    send(v);
    for (int t = 0; t < 161; t++) begin
      wave[t] = tx;
      dn[t] = tx_done_tick;
      @(negedge clk);
    end
    wave_bad = 0;
    dn_bad = 0;
    for (int t = 0; t < 161; t++) begin
      if (t < 16) want = 1'b0;
      else if (t < 144) want = v[(t - 16) / 16];
      else want = 1'b1;
      if (wave[t] !== want) wave_bad++;
      if (dn[t] !== (t == 160)) dn_bad++;
    end
    for (int i = 0; i < 8; i++) got[i] = wave[24 + 16 * i];
    total++;
    if (wave_bad != 0) begin
      bad++; $display("FAIL tickhigh_wave got=%0d_wrong_clks want=0", wave_bad);
    end
    total++;
    if (dn_bad != 0) begin
      bad++; $display("FAIL tickhigh_done got=%0d_wrong_clks want=0 (pulse at clk 160)", dn_bad);
    end
    total++;
    if (!pop_exp(e) || got !== e) begin
      bad++; $display("FAIL tickhigh_data got=%h want=%h", got, e);
    end
    tick_period = 4;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_back_to_back();
    test_stop_len();
    test_reset_mid();
    test_tick_high();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
